// File: rtl/alu_ctrl_pkg.sv
// Shared encodings for the ALU control decoder and the multiply/divide unit.
// MDU_DIV_EN adds the DIV state; without it the FSM has only IDLE, MUL and FIN.
package alu_ctrl_pkg;

  localparam logic [1:0] ALU_OP_ADD   = 2'b00;
  localparam logic [1:0] ALU_OP_SUB   = 2'b01;
  localparam logic [1:0] ALU_OP_RTYPE = 2'b10;
  localparam logic [1:0] ALU_OP_AND   = 2'b11;

  localparam logic [5:0] F_AND   = 6'b100100;
  localparam logic [5:0] F_OR    = 6'b100101;
  localparam logic [5:0] F_ADD   = 6'b100000;
  localparam logic [5:0] F_SUB   = 6'b100010;
  localparam logic [5:0] F_NOR   = 6'b100111;
  localparam logic [5:0] F_SLT   = 6'b101010;
  localparam logic [5:0] F_XOR   = 6'b100110;
  localparam logic [5:0] F_SLL   = 6'b000000;
  localparam logic [5:0] F_SRL   = 6'b000010;
  localparam logic [5:0] F_SRA   = 6'b000011;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MTLO  = 6'b010011;

  localparam logic [3:0] AC_AND = 4'b0000;
  localparam logic [3:0] AC_OR  = 4'b0001;
  localparam logic [3:0] AC_ADD = 4'b0010;
  localparam logic [3:0] AC_XOR = 4'b0100;
  localparam logic [3:0] AC_MUL = 4'b0101;
  localparam logic [3:0] AC_SUB = 4'b0110;
  localparam logic [3:0] AC_SLT = 4'b0111;
  localparam logic [3:0] AC_SLL = 4'b1000;
  localparam logic [3:0] AC_SRL = 4'b1001;
  localparam logic [3:0] AC_SRA = 4'b1010;
  localparam logic [3:0] AC_DIV = 4'b1011;
  localparam logic [3:0] AC_NOR = 4'b1100;

`ifdef MDU_DIV_EN
  typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1, DIV = 2'd2, FIN = 2'd3} mdu_state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1, FIN = 2'd3} mdu_state_t;
`endif

  function automatic logic [3:0] decode_alu_ctrl(input logic [1:0] op, input logic [5:0] f);
    logic [3:0] c;
    c = AC_AND;
    case (op)
      ALU_OP_ADD: c = AC_ADD;
      ALU_OP_SUB: c = AC_SUB;
      ALU_OP_AND: c = AC_AND;
      default: begin
        case (f)
          F_AND:            c = AC_AND;
          F_OR:             c = AC_OR;
          F_ADD:            c = AC_ADD;
          F_SUB:            c = AC_SUB;
          F_NOR:            c = AC_NOR;
          F_SLT:            c = AC_SLT;
          F_XOR:            c = AC_XOR;
          F_SLL:            c = AC_SLL;
          F_SRL:            c = AC_SRL;
          F_SRA:            c = AC_SRA;
          F_MULT, F_MULTU:  c = AC_MUL;
          F_DIV, F_DIVU:    c = AC_DIV;
          default:          c = AC_AND;
        endcase
      end
    endcase
    return c;
  endfunction

  function automatic logic is_mdu_funct(input logic [5:0] f);
    return (f == F_MULT) || (f == F_MULTU) || (f == F_DIV)  || (f == F_DIVU) ||
           (f == F_MFHI) || (f == F_MTHI)  || (f == F_MFLO) || (f == F_MTLO);
  endfunction

endpackage

// File: rtl/alu_ctrl_mdu_div_core.sv
// Restoring divider datapath: one quotient bit per step on unsigned operands.
// quotient/remainder show the values the registers take after this cycle's step.
module mdu_div_core #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] dividend,
  input  logic [DATA_W-1:0] divisor,
  input  logic              step,
  output logic [DATA_W-1:0] quotient,
  output logic [DATA_W-1:0] remainder
);

  logic [DATA_W-1:0] quo;
  logic [DATA_W-1:0] rem;
  logic [DATA_W-1:0] dsr;
  logic [DATA_W:0]   shifted;
  logic [DATA_W:0]   diff;
  logic              ge;

  // rem < dsr holds between steps, so the difference always fits DATA_W bits
  always_comb begin
    shifted   = {rem, quo[DATA_W-1]};
    diff      = shifted - {1'b0, dsr};
    ge        = shifted >= {1'b0, dsr};
    quotient  = {quo[DATA_W-2:0], ge};
    remainder = ge ? diff[DATA_W-1:0] : shifted[DATA_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      quo <= '0;
      rem <= '0;
      dsr <= '0;
    end else if (start) begin
      quo <= dividend;
      rem <= '0;
      dsr <= divisor;
    end else if (step) begin
      quo <= quotient;
      rem <= remainder;
    end
  end

endmodule

// File: rtl/alu_ctrl_mdu.sv
// ALU control decoder with an iterative HI/LO multiply/divide unit.
// Define MDU_DIV_EN to build the divider; otherwise div/divu retire as no-ops.
module alu_ctrl_mdu
  import alu_ctrl_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        alu_op,
  input  logic [5:0]        funct,
  input  logic              valid_in,
  output logic              ready_out,
  input  logic [DATA_W-1:0] rs_data,
  input  logic [DATA_W-1:0] rt_data,
  output logic [3:0]        alu_ctrl,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo,
  output logic [DATA_W-1:0] mf_data,
  output logic              mdu_busy,
  output logic              stall,
  output logic              done,
  output mdu_state_t        fsm_state
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  // Handshake: an instruction is taken on any edge where valid_in & ready_out;
  // only MDU ops are held off, and only while the MDU is busy.
  mdu_state_t          state;
  logic [CNT_W-1:0]    cnt;
  logic [2*DATA_W-1:0] prod;
  logic [DATA_W-1:0]   mcand;
  logic                neg_res;

  logic                is_rtype, mdu_op, accept, mdu_accept;
  logic                start_mul, wr_hi, wr_lo, last_iter;
  logic                op_signed, rs_neg, rt_neg;
  logic [DATA_W-1:0]   rs_mag, rt_mag;
  logic [DATA_W:0]     mul_sum;
  logic [2*DATA_W-1:0] prod_step, prod_fin;

  assign alu_ctrl   = decode_alu_ctrl(alu_op, funct);
  assign is_rtype   = (alu_op == ALU_OP_RTYPE);
  assign mdu_op     = is_rtype & is_mdu_funct(funct);
  assign stall      = valid_in & mdu_op & mdu_busy;
  assign ready_out  = ~stall;
  assign accept     = valid_in & ready_out;
  assign mdu_accept = accept & mdu_op;
  assign start_mul  = mdu_accept & ((funct == F_MULT) | (funct == F_MULTU));
  assign wr_hi      = mdu_accept & (funct == F_MTHI);
  assign wr_lo      = mdu_accept & (funct == F_MTLO);
  assign last_iter  = (cnt == CNT_W'(1));
  assign fsm_state  = state;

  // Even funct bit selects the signed variant for both mult and div
  assign op_signed = ~funct[0];
  assign rs_neg    = op_signed & rs_data[DATA_W-1];
  assign rt_neg    = op_signed & rt_data[DATA_W-1];
  assign rs_mag    = rs_neg ? -rs_data : rs_data;
  assign rt_mag    = rt_neg ? -rt_data : rt_data;

  always_comb begin
    mul_sum   = {1'b0, prod[2*DATA_W-1:DATA_W]} + (prod[0] ? {1'b0, mcand} : '0);
    prod_step = {mul_sum, prod[DATA_W-1:1]};
    prod_fin  = neg_res ? -prod_step : prod_step;
  end

  always_comb begin
    mf_data = '0;
    if (is_rtype && funct == F_MFHI) mf_data = hi;
    else if (is_rtype && funct == F_MFLO) mf_data = lo;
  end

`ifdef MDU_DIV_EN
  logic              start_div, neg_rem, div_zero;
  logic [DATA_W-1:0] rs_hold, quo_step, rem_step, quo_fin, rem_fin;

  assign start_div = mdu_accept & ((funct == F_DIV) | (funct == F_DIVU));

  mdu_div_core #(.DATA_W(DATA_W)) u_div (
    .clk       (clk),
    .reset     (reset),
    .start     (start_div),
    .dividend  (rs_mag),
    .divisor   (rt_mag),
    .step      (state == DIV),
    .quotient  (quo_step),
    .remainder (rem_step)
  );

  // Divide by zero overrides the sign fixup: HI returns the raw dividend
  always_comb begin
    quo_fin = div_zero ? '1 : (neg_res ? -quo_step : quo_step);
    rem_fin = div_zero ? rs_hold : (neg_rem ? -rem_step : rem_step);
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      prod     <= '0;
      mcand    <= '0;
      neg_res  <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      mdu_busy <= 1'b0;
      done     <= 1'b0;
`ifdef MDU_DIV_EN
      neg_rem  <= 1'b0;
      div_zero <= 1'b0;
      rs_hold  <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start_mul) begin
            prod     <= {{DATA_W{1'b0}}, rt_mag};
            mcand    <= rs_mag;
            neg_res  <= rs_neg ^ rt_neg;
            cnt      <= CNT_W'(DATA_W);
            state    <= MUL;
            mdu_busy <= 1'b1;
          end
`ifdef MDU_DIV_EN
          if (start_div) begin
            neg_res  <= rs_neg ^ rt_neg;
            neg_rem  <= rs_neg;
            div_zero <= (rt_data == '0);
            rs_hold  <= rs_data;
            cnt      <= CNT_W'(DATA_W);
            state    <= DIV;
            mdu_busy <= 1'b1;
          end
`endif
          if (wr_hi) hi <= rs_data;
          if (wr_lo) lo <= rs_data;
        end
        MUL: begin
          prod <= prod_step;
          cnt  <= cnt - CNT_W'(1);
          if (last_iter) begin
            hi    <= prod_fin[2*DATA_W-1:DATA_W];
            lo    <= prod_fin[DATA_W-1:0];
            state <= FIN;
            done  <= 1'b1;
          end
        end
`ifdef MDU_DIV_EN
        DIV: begin
          cnt <= cnt - CNT_W'(1);
          if (last_iter) begin
            hi    <= rem_fin;
            lo    <= quo_fin;
            state <= FIN;
            done  <= 1'b1;
          end
        end
`endif
        FIN: begin
          state    <= IDLE;
          mdu_busy <= 1'b0;
        end
        default: begin
          state    <= IDLE;
          mdu_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_ctrl_mdu.sv
// Directed bench for alu_ctrl_mdu at DATA_W=32; divider expectations follow MDU_DIV_EN.
module tb_alu_ctrl_mdu;
  import alu_ctrl_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic [1:0]   alu_op;
  logic [5:0]   funct;
  logic         valid_in;
  logic         ready_out;
  logic [W-1:0] rs_data, rt_data;
  logic [3:0]   alu_ctrl;
  logic [W-1:0] hi, lo, mf_data;
  logic         mdu_busy, stall, done;
  mdu_state_t   fsm_state;

  int checks = 0;
  int errors = 0;

  alu_ctrl_mdu #(.DATA_W(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .alu_op    (alu_op),
    .funct     (funct),
    .valid_in  (valid_in),
    .ready_out (ready_out),
    .rs_data   (rs_data),
    .rt_data   (rt_data),
    .alu_ctrl  (alu_ctrl),
    .hi        (hi),
    .lo        (lo),
    .mf_data   (mf_data),
    .mdu_busy  (mdu_busy),
    .stall     (stall),
    .done      (done),
    .fsm_state (fsm_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // drive one MDU op for one accept edge, then watch up to 40 cycles
  task automatic run_op(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                        output int busy_n, output int done_n, output int last_busy,
                        output int done_at, output logic [W-1:0] hi_d, output logic [W-1:0] lo_d);
    busy_n = 0; done_n = 0; last_busy = -1; done_at = -2; hi_d = 'x; lo_d = 'x;
    alu_op = ALU_OP_RTYPE; funct = f; rs_data = a; rt_data = b; valid_in = 1'b1;
    tick();
    valid_in = 1'b0; funct = F_ADD;
    for (int k = 1; k <= 40; k++) begin
      if (mdu_busy) begin busy_n++; last_busy = k; end
      if (done) begin done_n++; done_at = k; hi_d = hi; lo_d = lo; end
      tick();
    end
  endtask

  logic [1:0]   dec_op  [19] = '{2'b00, 2'b01, 2'b11, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10,
                                 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10};
  logic [5:0]   dec_fn  [19] = '{6'b100100, 6'b000000, 6'b100000, 6'b100100, 6'b100101, 6'b100000,
                                 6'b100010, 6'b100111, 6'b101010, 6'b100110, 6'b000000, 6'b000010,
                                 6'b000011, 6'b011000, 6'b011001, 6'b011010, 6'b011011, 6'b111111,
                                 6'b010000};
  logic [3:0]   dec_exp [19] = '{4'b0010, 4'b0110, 4'b0000, 4'b0000, 4'b0001, 4'b0010, 4'b0110,
                                 4'b1100, 4'b0111, 4'b0100, 4'b1000, 4'b1001, 4'b1010, 4'b0101,
                                 4'b0101, 4'b1011, 4'b1011, 4'b0000, 4'b0000};

  int           bn, dn, lb, da, stall_n, seen_busy, seen_done;
  logic [W-1:0] hd, ld, exp_hi, exp_lo;

  initial begin
    reset = 1'b1; valid_in = 1'b0; alu_op = 2'b00; funct = 6'd0; rs_data = '0; rt_data = '0;
    tick(); tick();
    reset = 1'b0;
    check("rst_busy", 64'(mdu_busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_hi", 64'(hi), 64'd0);
    check("rst_lo", 64'(lo), 64'd0);
    check("rst_ready", 64'(ready_out), 64'd1);
    check("rst_state", 64'(fsm_state), 64'(IDLE));

    // decode sweep, purely combinational
    for (int i = 0; i < 19; i++) begin
      alu_op = dec_op[i]; funct = dec_fn[i];
      #1;
      check($sformatf("dec_%0d", i), 64'(alu_ctrl), 64'(dec_exp[i]));
    end

    // mthi / mtlo and mf_data
    alu_op = ALU_OP_RTYPE; valid_in = 1'b1;
    funct = F_MTHI; rs_data = 32'hA5A5_A5A5; tick();
    funct = F_MTLO; rs_data = 32'h5A5A_0001; tick();
    valid_in = 1'b0;
    check("mthi", 64'(hi), 64'hA5A5_A5A5);
    check("mtlo", 64'(lo), 64'h5A5A_0001);
    funct = F_MFHI; #1; check("mfhi_data", 64'(mf_data), 64'hA5A5_A5A5);
    funct = F_MFLO; #1; check("mflo_data", 64'(mf_data), 64'h5A5A_0001);
    funct = F_ADD;  #1; check("mf_other", 64'(mf_data), 64'd0);
    tick();

    // signed mult -3 * 5
    run_op(F_MULT, 32'hFFFF_FFFD, 32'd5, bn, dn, lb, da, hd, ld);
    check("mult_busy_n", 64'(bn), 64'd33);
    check("mult_done_n", 64'(dn), 64'd1);
    check("mult_done_at", 64'(da), 64'(lb));
    check("mult_hi", 64'(hd), 64'hFFFF_FFFF);
    check("mult_lo", 64'(ld), 64'hFFFF_FFF1);
    exp_hi = 32'hFFFF_FFFF; exp_lo = 32'hFFFF_FFF1;

`ifdef MDU_DIV_EN
    run_op(F_DIVU, 32'd100, 32'd7, bn, dn, lb, da, hd, ld);
    check("divu_busy_n", 64'(bn), 64'd33);
    check("divu_done_n", 64'(dn), 64'd1);
    check("divu_lo", 64'(ld), 64'h0000_000E);
    check("divu_hi", 64'(hd), 64'h0000_0002);
    run_op(F_DIV, 32'hFFFF_FFF9, 32'd2, bn, dn, lb, da, hd, ld);
    check("div_lo", 64'(ld), 64'hFFFF_FFFD);
    check("div_hi", 64'(hd), 64'hFFFF_FFFF);
    run_op(F_DIV, 32'h0000_1234, 32'd0, bn, dn, lb, da, hd, ld);
    check("div0_hi", 64'(hd), 64'h0000_1234);
    check("div0_lo", 64'(ld), 64'hFFFF_FFFF);
    run_op(F_DIV, 32'h8000_0000, 32'hFFFF_FFFF, bn, dn, lb, da, hd, ld);
    check("divmin_lo", 64'(ld), 64'h8000_0000);
    check("divmin_hi", 64'(hd), 64'd0);
    exp_hi = 32'd0; exp_lo = 32'h8000_0000;
`else
    run_op(F_DIV, 32'h0000_1234, 32'd0, bn, dn, lb, da, hd, ld);
    check("div_off_busy", 64'(bn), 64'd0);
    check("div_off_done", 64'(dn), 64'd0);
    run_op(F_DIVU, 32'd100, 32'd7, bn, dn, lb, da, hd, ld);
    check("divu_off_busy", 64'(bn), 64'd0);
`endif
    check("hilo_hold_hi", 64'(hi), 64'(exp_hi));
    check("hilo_hold_lo", 64'(lo), 64'(exp_lo));

    // mfhi three cycles after a mult must stall until IDLE
    alu_op = ALU_OP_RTYPE; funct = F_MULTU; rs_data = 32'h0001_0000; rt_data = 32'h0001_0003;
    valid_in = 1'b1; tick();
    valid_in = 1'b0; tick(); tick();
    funct = F_MFHI; valid_in = 1'b1; #0;
    check("mfhi_stall", 64'(stall), 64'd1);
    check("mfhi_ready", 64'(ready_out), 64'd0);
    stall_n = 0;
    for (int k = 0; k < 40 && !ready_out; k++) begin
      if (stall) stall_n++;
      tick();
    end
    check("mfhi_released", 64'(ready_out), 64'd1);
    check("mfhi_stall_n", 64'(stall_n), 64'd31);
    check("mfhi_idle", 64'(mdu_busy), 64'd0);
    check("mfhi_new", 64'(mf_data), 64'h0000_0001);
    tick();
    valid_in = 1'b0;
    funct = F_MFLO; #1;
    check("mflo_new", 64'(mf_data), 64'h0003_0000);

    // non-MDU ops flow while busy
    funct = F_MULT; rs_data = 32'd7; rt_data = 32'd6; valid_in = 1'b1; tick();
    funct = F_ADD; #1;
    check("add_busy", 64'(mdu_busy), 64'd1);
    check("add_ready", 64'(ready_out), 64'd1);
    check("add_stall", 64'(stall), 64'd0);
    check("add_ctrl", 64'(alu_ctrl), 64'(4'b0010));
    alu_op = ALU_OP_ADD; funct = F_MTHI; #1;
    check("lw_ready", 64'(ready_out), 64'd1);
    valid_in = 1'b0;
    for (int k = 0; k < 40 && mdu_busy; k++) tick();
    check("mult42_lo", 64'(lo), 64'd42);
    check("mult42_hi", 64'(hi), 64'd0);

    // reset at cycle 10 of a mult aborts it
    alu_op = ALU_OP_RTYPE; funct = F_MULT; rs_data = 32'd9; rt_data = 32'd9; valid_in = 1'b1;
    tick();
    valid_in = 1'b0; funct = F_ADD;
    for (int k = 1; k < 10; k++) tick();
    reset = 1'b1; tick(); reset = 1'b0;
    check("abort_busy", 64'(mdu_busy), 64'd0);
    check("abort_hi", 64'(hi), 64'd0);
    check("abort_lo", 64'(lo), 64'd0);
    seen_busy = 0; seen_done = 0;
    for (int k = 0; k < 40; k++) begin
      if (mdu_busy) seen_busy++;
      if (done) seen_done++;
      tick();
    end
    check("abort_no_done", 64'(seen_done), 64'd0);
    check("abort_no_busy", 64'(seen_busy), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
